// File: rtl/pulse_len_tx.sv
// pulse_len_tx
// Measures the width, in clock cycles, of each high pulse on `in`. It then
// hands that width to a downstream consumer over a dav_/rfd handshake.
//
// Ports:
//   clock   - system clock; all state changes on its rising edge
//   reset_  - asynchronous active-low reset
//   in      - pulse to be measured, synchronous to clock
//   rfd     - consumer ready-for-data (1 = ready)
//   dav_    - data available, active low (0 = data valid)
//   data    - measured pulse width in cycles, saturating at 255
//
// The block only samples `in` in S_ARM, S_IDLE and S_MEAS. Pulses that occur
// while a transfer is in flight are dropped. S_ARM waits for `in` to go low
// before measuring. This stops a pulse that was already high at reset
// release, or at the end of a handshake, from being measured as a short
// partial width.

module pulse_len_tx (
    input  logic       clock,
    input  logic       reset_,
    input  logic       in,
    input  logic       rfd,
    output logic       dav_,
    output logic [7:0] data
);

    typedef enum logic [2:0] {
        S_ARM  = 3'd0,
        S_IDLE = 3'd1,
        S_MEAS = 3'd2,
        S_WRFD = 3'd3,
        S_WACK = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] count_r;
    logic [7:0] count_nxt_s;
    logic [7:0] data_nxt_s;
    logic       dav_nxt_s;

    // State, width counter and both registered outputs.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_r <= S_ARM;
            count_r <= 8'd0;
            data    <= 8'd0;
            dav_    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            data    <= data_nxt_s;
            dav_    <= dav_nxt_s;
        end
    end

    // Next-state logic and next values of the counter and the outputs.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        data_nxt_s  = data;
        dav_nxt_s   = dav_;

        case (state_r)
            S_ARM: begin
                dav_nxt_s = 1'b1;
                if (!in) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_ARM;
                end
            end

            S_IDLE: begin
                if (in) begin
                    count_nxt_s = 8'd1;
                    state_nxt_s = S_MEAS;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end

            S_MEAS: begin
                if (in) begin
                    // Saturate rather than wrap, so long pulses never report
                    // a small or zero width.
                    if (count_r != 8'd255) begin
                        count_nxt_s = count_r + 8'd1;
                    end else begin
                        count_nxt_s = count_r;
                    end
                end else begin
                    data_nxt_s  = count_r;
                    state_nxt_s = S_WRFD;
                end
            end

            S_WRFD: begin
                if (rfd) begin
                    dav_nxt_s   = 1'b0;
                    state_nxt_s = S_WACK;
                end else begin
                    state_nxt_s = S_WRFD;
                end
            end

            S_WACK: begin
                if (!rfd) begin
                    dav_nxt_s   = 1'b1;
                    state_nxt_s = S_ARM;
                end else begin
                    dav_nxt_s   = 1'b0;
                    state_nxt_s = S_WACK;
                end
            end

            default: begin
                dav_nxt_s   = 1'b1;
                state_nxt_s = S_ARM;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_len_tx.sv
// Self-checking bench for pulse_len_tx. The bench pushes an expected width
// onto a scoreboard queue whenever it drives a pulse that should be
// delivered. It pops and compares that width when dav_ falls.
module tb_pulse_len_tx;

    logic       clock;
    logic       reset_;
    logic       in;
    logic       rfd;
    logic       dav_;
    logic [7:0] data;

    int         checks;
    int         errors;
    logic [7:0] sb[$];

    pulse_len_tx dut (
        .clock  (clock),
        .reset_ (reset_),
        .in     (in),
        .rfd    (rfd),
        .dav_   (dav_),
        .data   (data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one n-cycle high pulse from an idle-low line. Stop after the edge
    // that samples the terminating 0, which is when data loads.
    task automatic drive_pulse(input int n, input bit expect_xfer);
        in = 1'b0;
        tick();
        in = 1'b1;
        repeat (n) tick();
        in = 1'b0;
        if (expect_xfer) sb.push_back((n > 255) ? 8'd255 : n[7:0]);
        tick();
    endtask

    // Raise rfd, wait (bounded) for dav_ to fall, then compare the delivered
    // width. Then release rfd and check that dav_ rises one edge later.
    task automatic finish_xfer(input string tag);
        int         waited;
        logic [7:0] exp;
        waited = 0;
        rfd = 1'b1;
        while (dav_ !== 1'b0 && waited < 64) begin
            tick();
            waited++;
        end
        check({tag, "_dav_fall"}, {31'd0, dav_}, 32'd0);
        check({tag, "_latency"}, waited, 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'd0;
        check({tag, "_data"}, {24'd0, data}, {24'd0, exp});
        rfd = 1'b0;
        tick();
        check({tag, "_dav_rise"}, {31'd0, dav_}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_ = 1'b0;
        in     = 1'b0;
        rfd    = 1'b0;
        repeat (3) tick();
        check("reset_dav", {31'd0, dav_}, 32'd1);
        check("reset_data", {24'd0, data}, 32'd0);
        reset_ = 1'b1;
        tick();

        // Basic 5-cycle pulse with rfd held high throughout.
        rfd = 1'b1;
        drive_pulse(5, 1'b1);
        check("basic_data_load", {24'd0, data}, 32'd5);
        check("basic_dav_before", {31'd0, dav_}, 32'd1);
        finish_xfer("basic");

        // Minimum width and saturation.
        drive_pulse(1, 1'b1);
        finish_xfer("min");
        drive_pulse(300, 1'b1);
        finish_xfer("sat");

        // Back-pressure: rfd stays low for 20 cycles after the pulse.
        rfd = 1'b0;
        drive_pulse(7, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_dav_hold", {31'd0, dav_}, 32'd1);
            check("bp_data_hold", {24'd0, data}, 32'd7);
        end
        finish_xfer("bp");

        // Lost pulse: a 3-cycle pulse while S_WACK holds dav_ low.
        rfd = 1'b1;
        drive_pulse(6, 1'b1);
        tick();
        check("lost_in_wack", {31'd0, dav_}, 32'd0);
        check("lost_first_data", {24'd0, data}, {24'd0, sb.pop_front()});
        in = 1'b1;
        repeat (3) tick();
        in = 1'b0;
        repeat (2) tick();
        check("lost_dav_still_low", {31'd0, dav_}, 32'd0);
        check("lost_data_kept", {24'd0, data}, 32'd6);
        rfd = 1'b0;
        tick();
        check("lost_dav_rise", {31'd0, dav_}, 32'd1);
        rfd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lost_no_xfer", {31'd0, dav_}, 32'd1);
        end
        drive_pulse(4, 1'b1);
        finish_xfer("after_lost");

        // Reset released while in is high: that pulse must not be measured.
        reset_ = 1'b0;
        #1;
        check("rst2_dav", {31'd0, dav_}, 32'd1);
        check("rst2_data", {24'd0, data}, 32'd0);
        in = 1'b1;
        tick();
        reset_ = 1'b1;
        rfd = 1'b1;
        repeat (6) tick();
        in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_in_high_no_xfer", {31'd0, dav_}, 32'd1);
        end
        check("rst_in_high_data", {24'd0, data}, 32'd0);
        drive_pulse(2, 1'b1);
        finish_xfer("after_rst_high");

        // Reset asserted mid-handshake: outputs clear without a clock edge.
        rfd = 1'b1;
        drive_pulse(9, 1'b1);
        tick();
        check("mid_dav_low", {31'd0, dav_}, 32'd0);
        check("mid_data", {24'd0, data}, {24'd0, sb.pop_front()});
        #2;
        reset_ = 1'b0;
        #1;
        check("mid_rst_dav", {31'd0, dav_}, 32'd1);
        check("mid_rst_data", {24'd0, data}, 32'd0);
        tick();
        reset_ = 1'b1;
        rfd = 1'b0;
        tick();
        drive_pulse(11, 1'b1);
        finish_xfer("after_mid_rst");

        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
